// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing
//  Purpose  : Raster timing generator. Runs horizontal/vertical position
//             counters on the dot clock and produces registered sync,
//             display-enable, pixel coordinates and line/frame strobes.
//             Defaults give 640x480 @ 60 Hz from a 25 MHz dot clock.
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             dotclock,
    input  logic             reset,
    output logic             hsync,
    output logic             vsync,
    output logic             display_enable,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             line_start,
    output logic             frame_start,
    output logic [7:0]       frame_count
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    // Decode boundaries sized to the counters so every compare is width-matched
    localparam logic [CNT_W-1:0] c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_BEGIN   = CNT_W'(H_ACTIVE + H_FRONT);
    localparam logic [CNT_W-1:0] c_HS_END     = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CNT_W-1:0] c_VS_BEGIN   = CNT_W'(V_ACTIVE + V_FRONT);
    localparam logic [CNT_W-1:0] c_VS_END     = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CNT_W-1:0] c_ZERO       = '0;

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;

    logic             w_h_last;
    logic             w_v_last;
    logic             w_de;
    logic             w_hs_act;
    logic             w_vs_act;
    logic             w_line_start;
    logic             w_frame_start;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_de;
    logic [CNT_W-1:0] r_pixel_x;
    logic [CNT_W-1:0] r_pixel_y;
    logic             r_line_start;
    logic             r_frame_start;
    logic [7:0]       r_frame_count;

    // Position decode from the current counter values
    always_comb begin
        w_h_last      = (r_h == c_H_LAST);
        w_v_last      = (r_v == c_V_LAST);
        w_de          = (r_h < c_H_ACT) && (r_v < c_V_ACT);
        w_hs_act      = (r_h >= c_HS_BEGIN) && (r_h < c_HS_END);
        w_vs_act      = (r_v >= c_VS_BEGIN) && (r_v < c_VS_END);
        w_line_start  = (r_h == c_ZERO);
        w_frame_start = (r_h == c_ZERO) && (r_v == c_ZERO);
    end

    // Raster counters: h wraps every line, v advances on h wrap and wraps per frame
    always_ff @(posedge dotclock or posedge reset) begin
        if (reset) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_h_last) begin
            r_h <= '0;
            r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
            r_h <= r_h + 1'b1;
        end
    end

    // Output registers: one dot of latency, all outputs aligned and glitch-free
    always_ff @(posedge dotclock or posedge reset) begin
        if (reset) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_de;
            r_pixel_x     <= r_h;
            r_pixel_y     <= r_v;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
            if (w_frame_start) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign hsync          = r_hsync;
    assign vsync          = r_vsync;
    assign display_enable = r_de;
    assign pixel_x        = r_pixel_x;
    assign pixel_y        = r_pixel_y;
    assign line_start     = r_line_start;
    assign frame_start    = r_frame_start;
    assign frame_count    = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing
//  Purpose  : Self-checking bench for vga_timing. A default 640x480 instance
//             and a small SYNC_POL=1 instance run side by side; expected
//             output vectors are queued per clock edge and compared later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    logic dotclock = 1'b0;
    logic rst_a    = 1'b1;
    logic rst_b    = 1'b1;

    // Default-parameter instance
    logic       a_hsync, a_vsync, a_de, a_ls, a_fs;
    logic [9:0] a_px, a_py;
    logic [7:0] a_fc;

    // Small instance: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), active-high syncs
    logic       b_hsync, b_vsync, b_de, b_ls, b_fs;
    logic [3:0] b_px, b_py;
    logic [7:0] b_fc;

    int n_checks = 0;
    int n_err    = 0;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];

    int k_a = 0;
    int k_b = 0;

    always #20 dotclock = ~dotclock;

    vga_timing u_dut_a (
        .dotclock       (dotclock),
        .reset          (rst_a),
        .hsync          (a_hsync),
        .vsync          (a_vsync),
        .display_enable (a_de),
        .pixel_x        (a_px),
        .pixel_y        (a_py),
        .line_start     (a_ls),
        .frame_start    (a_fs),
        .frame_count    (a_fc)
    );

    vga_timing #(
        .H_ACTIVE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_ACTIVE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_POL (1'b1), .CNT_W (4)
    ) u_dut_b (
        .dotclock       (dotclock),
        .reset          (rst_b),
        .hsync          (b_hsync),
        .vsync          (b_vsync),
        .display_enable (b_de),
        .pixel_x        (b_px),
        .pixel_y        (b_py),
        .line_start     (b_ls),
        .frame_start    (b_fs),
        .frame_count    (b_fc)
    );

    // Expected output vector after the k-th rising edge since reset release
    // (k = 0 means still in reset). Layout {hs, vs, de, ls, fs, fc[7:0], x[9:0], y[9:0]}.
    function automatic logic [32:0] exp_vec(int k, int ha, int hf, int hsw, int hb,
                                            int va, int vf, int vsw, int vb, bit pol);
        int ht, vt, pos, h, v, fr;
        logic hs_a, vs_a, de, ls, fs;
        if (k == 0) return {~pol, ~pol, 3'b000, 8'd0, 10'd0, 10'd0};
        ht   = ha + hf + hsw + hb;
        vt   = va + vf + vsw + vb;
        pos  = (k - 1) % (ht * vt);
        h    = pos % ht;
        v    = pos / ht;
        fr   = ((k - 1) / (ht * vt) + 1) % 256;
        hs_a = (h >= ha + hf) && (h < ha + hf + hsw);
        vs_a = (v >= va + vf) && (v < va + vf + vsw);
        de   = (h < ha) && (v < va);
        ls   = (h == 0);
        fs   = (h == 0) && (v == 0);
        return {hs_a ? pol : ~pol, vs_a ? pol : ~pol, de, ls, fs, 8'(fr), 10'(h), 10'(v)};
    endfunction

    function automatic logic [32:0] obs_a();
        return {a_hsync, a_vsync, a_de, a_ls, a_fs, a_fc, a_px, a_py};
    endfunction

    function automatic logic [32:0] obs_b();
        return {b_hsync, b_vsync, b_de, b_ls, b_fs, b_fc, 6'd0, b_px, 6'd0, b_py};
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One dot: push expectations at the edge, pop and compare at the falling edge
    task automatic step();
        @(posedge dotclock);
        if (!rst_a) k_a++;
        if (!rst_b) k_b++;
        q_a.push_back(exp_vec(k_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        q_b.push_back(exp_vec(k_b, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
        @(negedge dotclock);
        check("dut_a_outputs", obs_a(), q_a.pop_front());
        check("dut_b_outputs", obs_b(), q_b.pop_front());
    endtask

    initial begin
        int cnt_de, cnt_hs, min_hs_x, max_hs_x, last_ls_a, cnt_vs_b, prev_fc_b;
        bit seen_wrap;
        cnt_de = 0; cnt_hs = 0; min_hs_x = 1000; max_hs_x = -1;
        last_ls_a = 0; cnt_vs_b = 0; prev_fc_b = 0; seen_wrap = 1'b0;

        // Reset held: both instances must show reset values
        repeat (3) step();

        // Release both resets away from the active edge
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Run past 256 small frames (98 dots each) so frame_count wraps
        for (int i = 0; i < 25200; i++) begin
            step();
            if (k_a >= 1 && k_a <= 800) begin
                if (a_de) cnt_de++;
                if (!a_hsync) begin
                    cnt_hs++;
                    if (int'(a_px) < min_hs_x) min_hs_x = int'(a_px);
                    if (int'(a_px) > max_hs_x) max_hs_x = int'(a_px);
                end
            end
            if (a_ls) begin
                if (last_ls_a != 0) check("line_start_period", 33'(k_a - last_ls_a), 33'd800);
                last_ls_a = k_a;
            end
            if (k_b >= 1 && k_b <= 98 && b_vsync) cnt_vs_b++;
            if (b_fs && prev_fc_b == 255 && b_fc == 8'd0) seen_wrap = 1'b1;
            prev_fc_b = int'(b_fc);
        end

        check("de_cycles_per_line",   33'(cnt_de),   33'd640);
        check("hsync_cycles",         33'(cnt_hs),   33'd96);
        check("hsync_first_x",        33'(min_hs_x), 33'd656);
        check("hsync_last_x",         33'(max_hs_x), 33'd751);
        check("small_vsync_cycles",   33'(cnt_vs_b), 33'd14);
        check("frame_count_wrap",     33'(seen_wrap), 33'd1);

        // Move the small instance to (h,v) = (9,3), then reset it mid-frame
        for (int i = 0; i < 98 && ((k_b - 1) % 98) != 51; i++) step();
        check("pre_reset_pos", {23'd0, b_px, 2'd0, b_py}, {23'd0, 4'd9, 2'd0, 4'd3});
        #5;
        rst_b = 1'b1;
        k_b   = 0;
        #1;
        check("async_reset_now", obs_b(), exp_vec(0, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1));
        repeat (3) step();
        rst_b = 1'b0;
        step();
        check("first_dot_after_reset",
              {25'd0, b_fs, b_ls, b_fc[5:0]}, {25'd0, 1'b1, 1'b1, 6'd1});
        repeat (200) step();

        check("queues_drained", 33'(q_a.size() + q_b.size()), 33'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
